// File: rtl/region_max_window_pkg.sv
// Shared types and defaults for the regional-maximum window stage.
// Global config defines override the default geometry when present.
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

`ifndef CFG_IMG_WIDTH
`define CFG_IMG_WIDTH 64
`endif

`ifndef CFG_IMG_HEIGHT
`define CFG_IMG_HEIGHT 64
`endif

package region_max_window_pkg;

  localparam int DEF_DATA_WIDTH = `CFG_DATA_WIDTH;
  localparam int DEF_IMG_WIDTH  = `CFG_IMG_WIDTH;
  localparam int DEF_IMG_HEIGHT = `CFG_IMG_HEIGHT;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rmw_state_e;

  typedef logic [3:0] border_t;

  localparam border_t BORDER_TOP    = 4'b0001;
  localparam border_t BORDER_BOTTOM = 4'b0010;
  localparam border_t BORDER_LEFT   = 4'b0100;
  localparam border_t BORDER_RIGHT  = 4'b1000;

  // Which image edges the current centre pixel touches.
  function automatic border_t border_mask(
    input logic first_row,
    input logic last_row,
    input logic first_col,
    input logic last_col
  );
    border_t m;
    m = 4'b0000;
    if (first_row) m = m | BORDER_TOP;
    else           m = m;
    if (last_row)  m = m | BORDER_BOTTOM;
    else           m = m;
    if (first_col) m = m | BORDER_LEFT;
    else           m = m;
    if (last_col)  m = m | BORDER_RIGHT;
    else           m = m;
    return m;
  endfunction

endpackage

// File: rtl/rmw_line_buffer.sv
// One-row delay line: the output is the sample written DEPTH advances earlier.
// Read happens before write at the same slot, so no bypass path is needed.
module rmw_line_buffer
  import region_max_window_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_IMG_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_adv,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [PTR_W-1:0]      ptr_r;

  assign o_data = mem_r[ptr_r];

  // Circular slot pointer, one step per advance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_r <= '0;
    end else if (i_adv) begin
      if (ptr_r == PTR_LAST) ptr_r <= '0;
      else                   ptr_r <= ptr_r + PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Storage is left unreset; stale samples are masked downstream.
  always_ff @(posedge i_clk) begin
    if (i_adv) mem_r[ptr_r] <= i_data;
  end

endmodule

// File: rtl/region_max_window.sv
// 3x3 local-maximum flagger: pops raster pixels, builds the window from two
// line buffers and emits each pixel with its non-strict local-maximum flag.
module region_max_window
  import region_max_window_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_is_max,
  output logic                  o_last,
  output logic                  o_busy
);

  localparam int FILL_W  = $clog2(IMG_WIDTH + 2);
  localparam int FLUSH_W = $clog2(IMG_WIDTH + 1);

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [FILL_W-1:0]  FILL_DONE  = FILL_W'(IMG_WIDTH + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(IMG_WIDTH);

  // Neighbour order: above-right, above, above-left, right, left,
  // below-right, below, below-left. Each entry lists the edges that hide it.
  localparam border_t NB_EDGE [0:7] = '{
    BORDER_TOP | BORDER_RIGHT,
    BORDER_TOP,
    BORDER_TOP | BORDER_LEFT,
    BORDER_RIGHT,
    BORDER_LEFT,
    BORDER_BOTTOM | BORDER_RIGHT,
    BORDER_BOTTOM,
    BORDER_BOTTOM | BORDER_LEFT
  };

  rmw_state_e state_r, state_nxt_s;

  logic [COL_W-1:0]   in_col_r, c_col_r;
  logic [ROW_W-1:0]   in_row_r, c_row_r;
  logic [FLUSH_W-1:0] flush_cnt_r;
  logic [FILL_W-1:0]  fill_cnt_r;

  logic can_adv_s, ready_s, in_beat_s, flush_beat_s, adv_s;
  logic result_s, last_in_s, frame_end_s, last_res_s;
  logic valid_nxt_s, is_max_s;

  logic [DATA_WIDTH-1:0] tap0_s, tap1_s, tap2_s;
  logic [DATA_WIDTH-1:0] w00_r, w01_r, w10_r, w11_r, w20_r, w21_r;
  logic [DATA_WIDTH-1:0] nb_s [0:7];
  logic [DATA_WIDTH-1:0] nb_m_s;
  border_t               border_s;

  logic                  valid_r, is_max_r, last_r, busy_r;
  logic [DATA_WIDTH-1:0] data_r;

  assign can_adv_s   = ~valid_r | i_ready;
  assign last_in_s   = (in_row_r == ROW_LAST) & (in_col_r == COL_LAST);
  assign in_beat_s   = i_valid & ready_s;
  assign adv_s       = in_beat_s | flush_beat_s;
  assign result_s    = adv_s & (fill_cnt_r == FILL_DONE);
  assign frame_end_s = flush_beat_s & (flush_cnt_r == FLUSH_LAST);
  assign last_res_s  = (c_row_r == ROW_LAST) & (c_col_r == COL_LAST);

  // Next-state and pop/flush strobes.
  always_comb begin
    ready_s      = 1'b0;
    flush_beat_s = 1'b0;
    state_nxt_s  = state_r;
    case (state_r)
      ST_RUN: begin
        ready_s = can_adv_s;
        if (i_valid && can_adv_s && last_in_s) state_nxt_s = ST_FLUSH;
        else                                   state_nxt_s = ST_RUN;
      end
      ST_FLUSH: begin
        flush_beat_s = can_adv_s;
        if (can_adv_s && (flush_cnt_r == FLUSH_LAST)) state_nxt_s = ST_RUN;
        else                                          state_nxt_s = ST_FLUSH;
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Flush beats push zeros so the last rows drain through the window.
  always_comb begin
    tap0_s = i_data;
    if (flush_beat_s) tap0_s = '0;
    else              tap0_s = i_data;
  end

  // State, input position, flush, fill and centre position counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_RUN;
      in_col_r    <= '0;
      in_row_r    <= '0;
      flush_cnt_r <= '0;
      fill_cnt_r  <= '0;
      c_col_r     <= '0;
      c_row_r     <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (in_beat_s) begin
        if (in_col_r == COL_LAST) begin
          in_col_r <= '0;
          in_row_r <= (in_row_r == ROW_LAST) ? '0 : in_row_r + ROW_W'(1);
        end else begin
          in_col_r <= in_col_r + COL_W'(1);
        end
      end
      if (flush_beat_s) begin
        flush_cnt_r <= frame_end_s ? '0 : flush_cnt_r + FLUSH_W'(1);
      end
      if (frame_end_s) begin
        fill_cnt_r <= '0;
        c_col_r    <= '0;
        c_row_r    <= '0;
      end else begin
        if (adv_s && (fill_cnt_r != FILL_DONE)) fill_cnt_r <= fill_cnt_r + FILL_W'(1);
        if (result_s) begin
          if (c_col_r == COL_LAST) begin
            c_col_r <= '0;
            c_row_r <= (c_row_r == ROW_LAST) ? '0 : c_row_r + ROW_W'(1);
          end else begin
            c_col_r <= c_col_r + COL_W'(1);
          end
        end
      end
    end
  end

  rmw_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH)
  ) u_lb_near (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_adv  (adv_s),
    .i_data (tap0_s),
    .o_data (tap1_s)
  );

  rmw_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH)
  ) u_lb_far (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_adv  (adv_s),
    .i_data (tap1_s),
    .o_data (tap2_s)
  );

  // Two-column window history; the third column is the live taps.
  always_ff @(posedge i_clk) begin
    if (adv_s) begin
      w00_r <= tap0_s;
      w01_r <= w00_r;
      w10_r <= tap1_s;
      w11_r <= w10_r;
      w20_r <= tap2_s;
      w21_r <= w20_r;
    end
  end

  // Window as it will look after this advance, centre excluded.
  always_comb begin
    nb_s[0] = tap2_s;
    nb_s[1] = w20_r;
    nb_s[2] = w21_r;
    nb_s[3] = tap1_s;
    nb_s[4] = w11_r;
    nb_s[5] = tap0_s;
    nb_s[6] = w00_r;
    nb_s[7] = w01_r;
  end

  // Edge-masked non-strict maximum test against the eight neighbours.
  always_comb begin
    border_s = border_mask(c_row_r == '0, c_row_r == ROW_LAST,
                           c_col_r == '0, c_col_r == COL_LAST);
    is_max_s = 1'b1;
    nb_m_s   = '0;
    for (int i = 0; i < 8; i++) begin
      if (|(NB_EDGE[i] & border_s)) nb_m_s = '0;
      else                          nb_m_s = nb_s[i];
      if (nb_m_s > w10_r) is_max_s = 1'b0;
      else                is_max_s = is_max_s;
    end
  end

  // Result valid: set by a completed window, cleared once accepted.
  always_comb begin
    valid_nxt_s = valid_r;
    if (result_s)     valid_nxt_s = 1'b1;
    else if (i_ready) valid_nxt_s = 1'b0;
    else              valid_nxt_s = valid_r;
  end

  // Output registers; they only load on an advance, so stalls hold them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_r  <= 1'b0;
      data_r   <= '0;
      is_max_r <= 1'b0;
      last_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      valid_r <= valid_nxt_s;
      busy_r  <= (state_nxt_s == ST_FLUSH) | valid_nxt_s;
      if (result_s) begin
        data_r   <= w10_r;
        is_max_r <= is_max_s;
        last_r   <= last_res_s;
      end
    end
  end

  assign o_ready  = ready_s;
  assign o_valid  = valid_r;
  assign o_data   = data_r;
  assign o_is_max = is_max_r;
  assign o_last   = last_r;
  assign o_busy   = busy_r;

endmodule

// File: tb/tb_region_max_window.sv
// Scoreboard bench for region_max_window on a 4x4 image: expected results are
// queued from a reference neighbourhood model and popped on each output handshake.
module tb_region_max_window;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_is_max;
  logic          o_last;
  logic          o_busy;

  always #5 i_clk = ~i_clk;

  region_max_window #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_is_max (o_is_max),
    .o_last   (o_last),
    .o_busy   (o_busy)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          m;
    logic          l;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           n_cmp   = 0;
  int           n_err   = 0;
  int           res_cnt = 0;
  bit           sb_en   = 1'b0;
  logic [N-1:0] got_max;
  logic [DW-1:0] px [0:N-1];

  // Reference model: centre must be >= every in-image neighbour.
  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.d = px[r*W + c];
        e.m = 1'b1;
        e.l = (r == H-1) && (c == W-1);
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r+dr >= 0) && (r+dr < H) &&
                (c+dc >= 0) && (c+dc < W)) begin
              if (px[(r+dr)*W + (c+dc)] > e.d) e.m = 1'b0;
            end
          end
        end
        sb_q.push_back(e);
      end
    end
  endtask

  // Offer one pixel and keep it offered until popped; returns held-off cycles.
  task automatic send_pixel(input logic [DW-1:0] v, output int waits);
    waits   = 0;
    i_valid = 1'b1;
    i_data  = v;
    @(negedge i_clk);
    while (!o_ready && waits < 50) begin
      waits++;
      @(negedge i_clk);
    end
    if (!o_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_pixel: o_ready never rose for pixel %0d, required 1", v);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 200) begin
      @(negedge i_clk);
      cyc++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL %s drain: %0d results missing, required 0", name, sb_q.size());
      sb_q.delete();
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    repeat (3) @(posedge i_clk);
    #1;
    n_cmp++; if (o_valid !== 1'b0)   begin n_err++; $display("FAIL reset o_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_data !== 8'd0)    begin n_err++; $display("FAIL reset o_data: got %0d want 0", o_data); end
    n_cmp++; if (o_is_max !== 1'b0)  begin n_err++; $display("FAIL reset o_is_max: got %b want 0", o_is_max); end
    n_cmp++; if (o_last !== 1'b0)    begin n_err++; $display("FAIL reset o_last: got %b want 0", o_last); end
    n_cmp++; if (o_busy !== 1'b0)    begin n_err++; $display("FAIL reset o_busy: got %b want 0", o_busy); end
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    n_cmp++; if (o_ready !== 1'b1)   begin n_err++; $display("FAIL reset o_ready: got %b want 1", o_ready); end
  endtask

  task automatic test_ramp();
    int w;
    int lo;
    for (int i = 0; i < N; i++) px[i] = DW'(i);
    push_frame();
    for (int k = 0; k < N; k++) begin
      send_pixel(DW'(k), w);
      if (k == 4) begin
        n_cmp++;
        if (o_valid !== 1'b0) begin n_err++; $display("FAIL ramp first_valid_early: got %b want 0", o_valid); end
      end
      if (k == 5) begin
        n_cmp++;
        if (o_valid !== 1'b1) begin n_err++; $display("FAIL ramp first_valid: got %b want 1", o_valid); end
      end
    end
    lo = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_ready === 1'b0) lo++;
      else break;
    end
    n_cmp++;
    if (lo != W + 1) begin n_err++; $display("FAIL ramp flush_len: got %0d cycles want %0d", lo, W + 1); end
    wait_drain("ramp");
    n_cmp++;
    if (got_max !== 16'h8000) begin n_err++; $display("FAIL ramp max_map: got %h want 8000", got_max); end
    n_cmp++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL ramp idle_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_plateau();
    int w;
    for (int i = 0; i < N; i++) px[i] = 8'd10;
    px[6] = 8'd200;
    push_frame();
    for (int k = 0; k < N; k++) send_pixel(px[k], w);
    wait_drain("plateau");
    n_cmp++;
    if (got_max !== 16'hF151) begin n_err++; $display("FAIL plateau max_map: got %h want f151", got_max); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < N; i++) px[i] = DW'(i);
    push_frame();
    fork
      begin
        int w;
        for (int k = 0; k < N; k++) send_pixel(DW'(k), w);
      end
      begin
        int   base;
        int   cyc;
        exp_t held;
        base = res_cnt;
        cyc  = 0;
        while (res_cnt < base + 4 && cyc < 100) begin
          @(negedge i_clk);
          cyc++;
        end
        n_cmp++;
        if (res_cnt < base + 4) begin n_err++; $display("FAIL stall start: got %0d results want 4", res_cnt - base); end
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        held = {o_data, o_is_max, o_last};
        n_cmp++;
        if (o_valid !== 1'b1) begin n_err++; $display("FAIL stall pending: o_valid got %b want 1", o_valid); end
        for (int c = 0; c < 5; c++) begin
          @(negedge i_clk);
          n_cmp++;
          if ({o_data, o_is_max, o_last} !== held) begin
            n_err++;
            $display("FAIL stall hold: got %0d/%b/%b want %0d/%b/%b", o_data, o_is_max, o_last, held.d, held.m, held.l);
          end
          n_cmp++;
          if (o_ready !== 1'b0) begin n_err++; $display("FAIL stall o_ready: got %b want 0", o_ready); end
        end
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    wait_drain("stall");
  endtask

  task automatic test_bubbles();
    int w;
    int gaps;
    gaps = 0;
    for (int i = 0; i < N; i++) px[i] = DW'(i);
    push_frame();
    for (int k = 0; k < N; k++) begin
      send_pixel(DW'(k), w);
      @(posedge i_clk);
      #1;
      if (k >= 5 && o_valid === 1'b0) gaps++;
    end
    wait_drain("bubbles");
    n_cmp++;
    if (gaps != 10) begin n_err++; $display("FAIL bubbles gaps: got %0d want 10", gaps); end
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < N; i++) px[i] = 8'd255;
    push_frame();
    for (int i = 0; i < N; i++) px[i] = 8'd0;
    push_frame();
    for (int k = 0; k < N; k++) send_pixel(8'd255, w);
    for (int k = 0; k < N; k++) begin
      send_pixel(8'd0, w);
      if (k == 0) begin
        n_cmp++;
        if (w != W + 1) begin n_err++; $display("FAIL b2b holdoff: got %0d cycles want %0d", w, W + 1); end
      end
    end
    wait_drain("b2b");
    n_cmp++;
    if (got_max !== 16'hFFFF) begin n_err++; $display("FAIL b2b frame2_max: got %h want ffff", got_max); end
  endtask

  task automatic test_reset_mid();
    int w;
    sb_en = 1'b0;
    for (int k = 0; k < 7; k++) send_pixel(8'd200 - DW'(k), w);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    n_cmp++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid o_valid: got %b want 0", o_valid); end
    n_cmp++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid o_busy: got %b want 0", o_busy); end
    sb_en = 1'b1;
    for (int i = 0; i < N; i++) px[i] = DW'(i);
    push_frame();
    for (int k = 0; k < N; k++) send_pixel(DW'(k), w);
    wait_drain("rst_mid");
    n_cmp++;
    if (got_max !== 16'h8000) begin n_err++; $display("FAIL rst_mid max_map: got %h want 8000", got_max); end
  endtask

  initial begin
    got_max = '0;
    fork
      forever begin
        @(negedge i_clk);
        if (sb_en && o_valid === 1'b1 && i_ready === 1'b1 && i_rst === 1'b0) begin
          n_cmp++;
          if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL result unexpected: got %0d/%b/%b want none", o_data, o_is_max, o_last);
          end else begin
            mon_e = sb_q.pop_front();
            if ({o_data, o_is_max, o_last} !== mon_e) begin
              n_err++;
              $display("FAIL result %0d: got data/max/last %0d/%b/%b want %0d/%b/%b",
                       res_cnt, o_data, o_is_max, o_last, mon_e.d, mon_e.m, mon_e.l);
            end
            got_max[res_cnt % N] = o_is_max;
            res_cnt++;
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
      end
    join_none

    test_reset();
    sb_en = 1'b1;
    test_ramp();
    test_plateau();
    test_stall();
    test_bubbles();
    test_back_to_back();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
